// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way bus arbiter, fixed-priority or round-robin, with optional hold-time preemption
module rr_arbiter #(
  parameter int NUMBER_OF_DEVICES   = 4,
  parameter int DEVICE_NUMBER_WIDTH = NUMBER_OF_DEVICES > 2 ? $clog2(NUMBER_OF_DEVICES) : 1,
  parameter int ROUND_ROBIN         = 1,
  parameter int MAX_HOLD_CYCLES     = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUMBER_OF_DEVICES-1:0]   request,
  output logic [NUMBER_OF_DEVICES-1:0]   grant,
  output logic                           grant_valid,
  output logic [DEVICE_NUMBER_WIDTH-1:0] owner,
  output logic                           preempted
);
  localparam int N  = NUMBER_OF_DEVICES;
  localparam int DW = DEVICE_NUMBER_WIDTH;
  localparam int HW = MAX_HOLD_CYCLES > 0 ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t          state, state_n;
  logic [N-1:0]    grant_n, mask, mask_n, eligible;
  logic [DW-1:0]   owner_n, ptr, ptr_n, winner, idx;
  logic [HW-1:0]   hold, hold_n;
  logic            preempted_n;
  // winner search: the just-preempted device steps aside only if someone else is asking
  always_comb begin
    eligible = |(request & ~mask) ? request & ~mask : request;
    winner   = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = DW'(((ROUND_ROBIN != 0 ? int'(ptr) : 0) + k) % N);
      winner = eligible[idx] ? idx : winner;
    end
  end
  // next state: arbitrate in IDLE, hold or release/preempt in GRANTED
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    owner_n     = owner;
    ptr_n       = ptr;
    hold_n      = hold;
    mask_n      = mask;
    preempted_n = 1'b0;
    if (state == IDLE) begin
      mask_n = '0;
      if (|eligible) begin
        state_n = GRANTED;
        grant_n = N'(1) << winner;
        owner_n = winner;
        hold_n  = HW'(1);
        ptr_n   = winner == DW'(N - 1) ? '0 : winner + 1'b1;
      end
    end else if (!request[owner]) begin
      state_n = IDLE;
      grant_n = '0;
      hold_n  = '0;
    end else if (MAX_HOLD_CYCLES != 0 && hold == HW'(MAX_HOLD_CYCLES)) begin
      state_n     = IDLE;
      grant_n     = '0;
      hold_n      = '0;
      preempted_n = 1'b1;
      mask_n      = grant;
    end else begin
      hold_n = hold + HW'(hold != '1);
    end
  end
  // state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      preempted   <= 1'b0;
      ptr         <= '0;
      hold        <= '0;
      mask        <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= |grant_n;
      owner       <= owner_n;
      preempted   <= preempted_n;
      ptr         <= ptr_n;
      hold        <= hold_n;
      mask        <= mask_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of fixed-priority, round-robin and hold-timeout arbiters
module tb_rr_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] g_a, g_b, g_c;
  logic       v_a, v_b, v_c, p_a, p_b, p_c;
  logic [1:0] o_a, o_b, o_c;
  int         n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  rr_arbiter #(.NUMBER_OF_DEVICES(4), .ROUND_ROBIN(0), .MAX_HOLD_CYCLES(0)) dut_fp (
    .clock(clock), .reset(reset), .request(req_a), .grant(g_a), .grant_valid(v_a), .owner(o_a), .preempted(p_a));
  rr_arbiter #(.NUMBER_OF_DEVICES(4), .ROUND_ROBIN(1), .MAX_HOLD_CYCLES(0)) dut_rr (
    .clock(clock), .reset(reset), .request(req_b), .grant(g_b), .grant_valid(v_b), .owner(o_b), .preempted(p_b));
  rr_arbiter #(.NUMBER_OF_DEVICES(4), .ROUND_ROBIN(0), .MAX_HOLD_CYCLES(4)) dut_hold (
    .clock(clock), .reset(reset), .request(req_c), .grant(g_c), .grant_valid(v_c), .owner(o_c), .preempted(p_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic v, input logic [1:0] o, input logic p,
                      input logic [3:0] eg, input logic [1:0] eo, input logic ep);
    check({tag, ".grant"}, 32'(g), 32'(eg));
    check({tag, ".valid"}, 32'(v), 32'(|eg));
    if (|eg) check({tag, ".owner"}, 32'(o), 32'(eo));
    check({tag, ".preempted"}, 32'(p), 32'(ep));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick();
    tick();
    outs("reset_fp", g_a, v_a, o_a, p_a, 4'b0000, 2'd0, 1'b0);
    check("reset_fp.owner0", 32'(o_a), 0);
    outs("reset_rr", g_b, v_b, o_b, p_b, 4'b0000, 2'd0, 1'b0);
    outs("reset_hold", g_c, v_c, o_c, p_c, 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    // fixed priority: lowest index wins
    req_a = 4'b1010;
    tick();
    outs("fp_1010", g_a, v_a, o_a, p_a, 4'b0010, 2'd1, 1'b0);
    req_a = 4'b0000;
    tick();
    outs("fp_release", g_a, v_a, o_a, p_a, 4'b0000, 2'd0, 1'b0);
    req_a = 4'b1100;
    tick();
    outs("fp_1100", g_a, v_a, o_a, p_a, 4'b0100, 2'd2, 1'b0);
    req_a = 4'b0000;
    tick();
    outs("fp_release2", g_a, v_a, o_a, p_a, 4'b0000, 2'd0, 1'b0);
    // round robin: all requesting, each owner holds 3 cycles then drops
    req_b = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      outs($sformatf("rr_turn%0d", i), g_b, v_b, o_b, p_b, 4'b0001 << (i % 4), 2'(i % 4), 1'b0);
      tick();
      tick();
      check($sformatf("rr_hold%0d", i), 32'(g_b), 32'(4'b0001 << (i % 4)));
      req_b = 4'b1111 & ~(4'b0001 << (i % 4));
      tick();
      outs($sformatf("rr_gap%0d", i), g_b, v_b, o_b, p_b, 4'b0000, 2'd0, 1'b0);
      req_b = 4'b1111;
    end
    req_b = 4'b0000;
    tick();
    // pointer at 3 wraps to 0
    req_b = 4'b0100;
    tick();
    outs("rr_set_ptr3", g_b, v_b, o_b, p_b, 4'b0100, 2'd2, 1'b0);
    req_b = 4'b0000;
    tick();
    req_b = 4'b1001;
    tick();
    outs("rr_ptr3", g_b, v_b, o_b, p_b, 4'b1000, 2'd3, 1'b0);
    req_b = 4'b0000;
    tick();
    req_b = 4'b1001;
    tick();
    outs("rr_wrap0", g_b, v_b, o_b, p_b, 4'b0001, 2'd0, 1'b0);
    req_b = 4'b0000;
    tick();
    // hold timeout with another requester waiting
    req_c = 4'b0100;
    tick();
    req_c = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      outs($sformatf("hold_c%0d", c), g_c, v_c, o_c, p_c, 4'b0100, 2'd2, 1'b0);
    end
    tick();
    outs("hold_expire", g_c, v_c, o_c, p_c, 4'b0000, 2'd0, 1'b1);
    tick();
    outs("hold_next0", g_c, v_c, o_c, p_c, 4'b0001, 2'd0, 1'b0);
    req_c = 4'b0000;
    tick();
    tick();
    // mask overrides fixed priority
    req_c = 4'b1010;
    tick();
    tick();
    tick();
    tick();
    check("mask_c4", 32'(g_c), 32'(4'b0010));
    tick();
    outs("mask_expire", g_c, v_c, o_c, p_c, 4'b0000, 2'd0, 1'b1);
    tick();
    outs("mask_to3", g_c, v_c, o_c, p_c, 4'b1000, 2'd3, 1'b0);
    req_c = 4'b0000;
    tick();
    tick();
    // sole requester is regranted after preemption; release at expiry is not a preemption
    req_c = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    tick();
    outs("sole_expire", g_c, v_c, o_c, p_c, 4'b0000, 2'd0, 1'b1);
    tick();
    outs("sole_regrant", g_c, v_c, o_c, p_c, 4'b0100, 2'd2, 1'b0);
    tick();
    tick();
    tick();
    check("sole_c4", 32'(g_c), 32'(4'b0100));
    req_c = 4'b0000;
    tick();
    outs("release_at_expiry", g_c, v_c, o_c, p_c, 4'b0000, 2'd0, 1'b0);
    tick();
    check("quiet_after", 32'(p_c), 0);
    // reset mid-grant
    req_b = 4'b0100;
    tick();
    outs("pre_reset", g_b, v_b, o_b, p_b, 4'b0100, 2'd2, 1'b0);
    reset = 1'b1;
    tick();
    outs("mid_reset", g_b, v_b, o_b, p_b, 4'b0000, 2'd0, 1'b0);
    check("mid_reset.owner0", 32'(o_b), 0);
    reset = 1'b0;
    req_b = 4'b1010;
    tick();
    outs("post_reset_ptr0", g_b, v_b, o_b, p_b, 4'b0010, 2'd1, 1'b0);
    req_b = 4'b0000;
    tick();
    req_b = 4'b0100;
    tick();
    outs("post_reset_0100", g_b, v_b, o_b, p_b, 4'b0100, 2'd2, 1'b0);
    req_b = 4'b0000;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
